dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//    Single-port data memory controller for a RISC-V style load/store unit.
//    Accepts one request every other cycle (IDLE -> RESP -> IDLE), performs
//    byte/half/word stores with lane merging and byte/half/word loads with
//    sign or zero extension. Misaligned or illegal-size requests are rejected
//    with a one-cycle err pulse and have no side effect.
//
// Parameters
//    MEM_DEPTH : number of 32-bit words (power of two, >= 4)
//    ADDR_W    : byte-address width
//
// Ports
//    clock     : clock, all state changes on the rising edge
//    reset_n   : synchronous active-low reset (memory contents are kept)
//    req       : access request, sampled only while ready = 1
//    wren      : 1 = store, 0 = load
//    funct3    : RISC-V size code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//    address   : byte address
//    data_in   : store data (low byte/half/word used)
//    ready     : controller can accept a request this cycle (IDLE)
//    data_out  : load result, held until the next load response
//    rvalid    : one-cycle pulse, data_out valid
//    wack      : one-cycle pulse, store committed
//    err       : one-cycle pulse, request rejected
// -----------------------------------------------------------------------------
module dmem_ctrl #(
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH) + 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req,
   input  logic              wren,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       data_in,
   output logic              ready,
   output logic [31:0]       data_out,
   output logic              rvalid,
   output logic              wack,
   output logic              err
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   logic [31:0] mem_q [MEM_DEPTH];

   // ---------------------------------------------------------------------------
   // Registered FSM state and outputs
   // ---------------------------------------------------------------------------
   state_t      state_q,    state_d;
   logic        ready_q,    ready_d;
   logic [31:0] data_out_q, data_out_d;
   logic        rvalid_q,   rvalid_d;
   logic        wack_q,     wack_d;
   logic        err_q,      err_d;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic [ADDR_W-3:0] word_idx;
   logic [1:0]        lane;
   logic              accept;
   logic              f3_legal;
   logic              misaligned;
   logic              req_ok;
   logic              mem_we;
   logic [3:0]        byte_en;
   logic [31:0]       wr_data;
   logic [31:0]       rd_word;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       rd_ext;

   assign word_idx = address[ADDR_W-1:2];
   assign lane     = address[1:0];

   // ready_q is 1 exactly in IDLE, so it doubles as the accept qualifier.
   assign accept   = ready_q & req;

   always_comb begin
      f3_legal = 1'b0;
      if (wren) begin
         f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end else begin
         f3_legal = (funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
      end
   end

   // funct3[1:0] encodes the access size for every legal code.
   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = (lane != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   assign req_ok = f3_legal & ~misaligned;

   // Writes are gated by reset_n so requests seen during reset are ignored.
   assign mem_we = reset_n & accept & wren & req_ok;

   // ---------------------------------------------------------------------------
   // Store lane selection and data replication
   // ---------------------------------------------------------------------------
   always_comb begin
      byte_en = '0;
      wr_data = data_in;
      case (funct3[1:0])
         2'b00: begin
            byte_en       = 4'b0001 << lane;
            wr_data       = {4{data_in[7:0]}};
         end
         2'b01: begin
            byte_en       = lane[1] ? 4'b1100 : 4'b0011;
            wr_data       = {2{data_in[15:0]}};
         end
         2'b10: begin
            byte_en       = 4'b1111;
            wr_data       = data_in;
         end
         default: begin
            byte_en       = '0;
            wr_data       = data_in;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Load extraction and extension (captured into data_out at the accept edge)
   // ---------------------------------------------------------------------------
   assign rd_word = mem_q[word_idx];

   always_comb begin
      rd_byte = rd_word[7:0];
      case (lane)
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
   end

   assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      rd_ext = rd_word;
      case (funct3)
         F3_B:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
         F3_H:    rd_ext = {{16{rd_half[15]}}, rd_half};
         F3_BU:   rd_ext = {24'h0, rd_byte};
         F3_HU:   rd_ext = {16'h0, rd_half};
         default: rd_ext = rd_word;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      data_out_d = data_out_q;
      rvalid_d   = 1'b0;
      wack_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = RESP;
               ready_d = 1'b0;
               if (!req_ok) begin
                  err_d = 1'b1;
               end else if (wren) begin
                  wack_d = 1'b1;
               end else begin
                  rvalid_d   = 1'b1;
                  data_out_d = rd_ext;
               end
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         data_out_q <= '0;
         rvalid_q   <= 1'b0;
         wack_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         data_out_q <= data_out_d;
         rvalid_q   <= rvalid_d;
         wack_q     <= wack_d;
         err_q      <= err_d;
      end
   end

   assign ready    = ready_q;
   assign data_out = data_out_q;
   assign rvalid   = rvalid_q;
   assign wack     = wack_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//    Directed scoreboard bench for dmem_ctrl. The driver pushes the expected
//    response of every request it issues; a negedge monitor pops and compares
//    whenever rvalid, wack or err is presented.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

   localparam int K_RD = 0;
   localparam int K_WA = 1;
   localparam int K_ER = 2;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic        wren = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [11:0] address = '0;
   logic [31:0] data_in = '0;
   logic        ready;
   logic [31:0] data_out;
   logic        rvalid;
   logic        wack;
   logic        err;

   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   dmem_ctrl #(
      .MEM_DEPTH(1024)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req),
      .wren    (wren),
      .funct3  (funct3),
      .address (address),
      .data_in (data_in),
      .ready   (ready),
      .data_out(data_out),
      .rvalid  (rvalid),
      .wack    (wack),
      .err     (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, expv);
      end
   endtask

   // Monitor: pulse exclusivity plus scoreboard pop on every response.
   always @(negedge clock) begin
      if (mon_en) begin
         int   n;
         exp_t e;
         n = int'(rvalid) + int'(wack) + int'(err);
         if (ready) chk("idle_quiet", n, 0);
         else       chk("resp_onehot", n, 1);
         if (n != 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", {29'h0, err, wack, rvalid}, 32'h0);
            end else begin
               int got;
               e   = exp_q.pop_front();
               got = rvalid ? K_RD : (wack ? K_WA : K_ER);
               chk("resp_kind", got, e.kind);
               if (e.kind == K_RD) chk("load_data", data_out, e.data);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge of the RESP cycle.
   task automatic issue(input logic w, input logic [2:0] f, input logic [11:0] a,
                        input logic [31:0] d, input int k, input logic [31:0] ed);
      int   n;
      exp_t e;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!ready) begin
         chk("ready_timeout", 32'(ready), 32'h1);
         return;
      end
      req     = 1'b1;
      wren    = w;
      funct3  = f;
      address = a;
      data_in = d;
      e.kind  = k;
      e.data  = ed;
      exp_q.push_back(e);
      @(negedge clock);
      req = 1'b0;
      chk("latency_1", 32'(rvalid | wack | err), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_ready", 32'(ready), 32'h1);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_pulses", {29'h0, err, wack, rvalid}, 32'h0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clock);

      // Word round trip
      issue(1'b1, 3'b010, 12'h0D4, 32'h0000_0035, K_WA, '0);
      issue(1'b0, 3'b010, 12'h0D4, '0,            K_RD, 32'h0000_0035);

      // Byte merge and sign extension
      issue(1'b1, 3'b010, 12'h010, 32'h1122_3344, K_WA, '0);
      issue(1'b1, 3'b000, 12'h011, 32'h0000_00F0, K_WA, '0);
      issue(1'b0, 3'b010, 12'h010, '0,            K_RD, 32'h1122_F044);
      issue(1'b0, 3'b000, 12'h011, '0,            K_RD, 32'hFFFF_FFF0);
      issue(1'b0, 3'b100, 12'h011, '0,            K_RD, 32'h0000_00F0);

      // data_out holds across a store
      issue(1'b0, 3'b010, 12'h010, '0,            K_RD, 32'h1122_F044);
      issue(1'b1, 3'b000, 12'h07C, 32'h0000_0077, K_WA, '0);
      @(negedge clock);
      chk("data_out_hold", data_out, 32'h1122_F044);

      // Half access
      issue(1'b1, 3'b010, 12'h020, 32'hAAAA_5555, K_WA, '0);
      issue(1'b1, 3'b001, 12'h022, 32'h0000_8001, K_WA, '0);
      issue(1'b0, 3'b001, 12'h022, '0,            K_RD, 32'hFFFF_8001);
      issue(1'b0, 3'b101, 12'h022, '0,            K_RD, 32'h0000_8001);
      issue(1'b0, 3'b010, 12'h020, '0,            K_RD, 32'h8001_5555);

      // Every byte lane
      issue(1'b1, 3'b010, 12'h040, 32'h0000_0000, K_WA, '0);
      issue(1'b1, 3'b000, 12'h040, 32'hFFFF_FF11, K_WA, '0);
      issue(1'b1, 3'b000, 12'h041, 32'h0000_0022, K_WA, '0);
      issue(1'b1, 3'b000, 12'h042, 32'h0000_0033, K_WA, '0);
      issue(1'b1, 3'b000, 12'h043, 32'h0000_0044, K_WA, '0);
      issue(1'b0, 3'b010, 12'h040, '0,            K_RD, 32'h4433_2211);
      issue(1'b0, 3'b001, 12'h040, '0,            K_RD, 32'h0000_2211);
      issue(1'b0, 3'b101, 12'h042, '0,            K_RD, 32'h0000_4433);
      issue(1'b0, 3'b000, 12'h043, '0,            K_RD, 32'h0000_0044);

      // Misaligned access
      issue(1'b1, 3'b010, 12'h004, 32'h0102_0304, K_WA, '0);
      issue(1'b1, 3'b010, 12'h006, 32'hDEAD_BEEF, K_ER, '0);
      issue(1'b1, 3'b001, 12'h005, 32'h0000_BEEF, K_ER, '0);
      issue(1'b0, 3'b010, 12'h004, '0,            K_RD, 32'h0102_0304);
      issue(1'b0, 3'b001, 12'h003, '0,            K_ER, '0);
      issue(1'b0, 3'b010, 12'h002, '0,            K_ER, '0);

      // Illegal funct3
      issue(1'b0, 3'b011, 12'h0D4, '0,            K_ER, '0);
      issue(1'b0, 3'b110, 12'h0D4, '0,            K_ER, '0);
      issue(1'b0, 3'b111, 12'h0D4, '0,            K_ER, '0);
      issue(1'b1, 3'b100, 12'h0D4, 32'hFFFF_FFFF, K_ER, '0);
      issue(1'b1, 3'b011, 12'h0D4, 32'hFFFF_FFFF, K_ER, '0);
      issue(1'b0, 3'b010, 12'h0D4, '0,            K_RD, 32'h0000_0035);

      // Top of the address space
      issue(1'b1, 3'b010, 12'hFFC, 32'h0000_0000, K_WA, '0);
      issue(1'b1, 3'b000, 12'hFFF, 32'h0000_009C, K_WA, '0);
      issue(1'b0, 3'b100, 12'hFFF, '0,            K_RD, 32'h0000_009C);
      issue(1'b0, 3'b000, 12'hFFF, '0,            K_RD, 32'hFFFF_FF9C);
      issue(1'b0, 3'b010, 12'hFFC, '0,            K_RD, 32'h9C00_0000);

      // Reset during RESP of a store: store stays written; requests in reset ignored
      issue(1'b1, 3'b010, 12'h050, 32'h5A5A_0000, K_WA, '0);
      reset_n = 1'b0;
      req     = 1'b1;
      wren    = 1'b0;
      funct3  = 3'b010;
      address = 12'h050;
      @(negedge clock);
      chk("rst_resp_ready", 32'(ready), 32'h1);
      chk("rst_resp_data_out", data_out, 32'h0);
      wren    = 1'b1;
      data_in = 32'hFFFF_FFFF;
      @(negedge clock);
      chk("rst_hold_pulses", {29'h0, err, wack, rvalid}, 32'h0);
      reset_n = 1'b1;
      req     = 1'b0;
      @(negedge clock);
      issue(1'b0, 3'b010, 12'h050, '0,            K_RD, 32'h5A5A_0000);

      // Reset during RESP of a load, with a load presented while in reset
      issue(1'b0, 3'b010, 12'h0D4, '0,            K_RD, 32'h0000_0035);
      reset_n = 1'b0;
      req     = 1'b1;
      wren    = 1'b0;
      funct3  = 3'b010;
      address = 12'h0D4;
      @(negedge clock);
      chk("rst_load_rvalid", 32'(rvalid), 32'h0);
      chk("rst_load_data_out", data_out, 32'h0);
      chk("rst_load_ready", 32'(ready), 32'h1);
      reset_n = 1'b1;
      req     = 1'b0;
      @(negedge clock);
      issue(1'b0, 3'b010, 12'h010, '0,            K_RD, 32'h1122_F044);

      // Throughput: req held high -> accepts every other cycle
      @(negedge clock);
      chk("tput_start_ready", 32'(ready), 32'h1);
      req     = 1'b1;
      wren    = 1'b0;
      funct3  = 3'b010;
      address = 12'h0D4;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.kind = K_RD;
         e.data = 32'h0000_0035;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("tput_ready", 32'(ready), (i % 2 == 0) ? 32'h0 : 32'h1);
      end
      req = 1'b0;

      repeat (4) @(negedge clock);
      chk("queue_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
